// File: rtl/onehot_codec.sv
// onehot_codec: registered binary <-> one-hot converter with 2-entry skid.
// Define ONEHOT_CODEC_ERR_EN to enable decode error flag and err_count.
module onehot_codec #(
    parameter int BIN_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_mode,
    input  logic [BIN_WIDTH-1:0]        in_bin,
    input  logic [(1<<BIN_WIDTH)-1:0]   in_onehot,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_mode,
    output logic [(1<<BIN_WIDTH)-1:0]   out_onehot,
    output logic [BIN_WIDTH-1:0]        out_bin,
    output logic                        out_err,
    output logic [7:0]                  err_count
);

    localparam int ONEHOT_WIDTH = 1 << BIN_WIDTH;

    typedef struct packed {
        logic                    mode;
        logic [BIN_WIDTH-1:0]    bin;
        logic [ONEHOT_WIDTH-1:0] onehot;
        logic                    err;
    } entry_t;

    entry_t res;
    entry_t m_q;
    entry_t s_q;
    logic   m_full;
    logic   s_full;
    logic   in_fire;
    logic   out_fire;

    assign in_ready = !s_full;
    assign out_valid = m_full;
    assign in_fire = in_valid && in_ready;
    assign out_fire = m_full && out_ready;

    assign out_mode = m_q.mode;
    assign out_bin = m_q.bin;
    assign out_onehot = m_q.onehot;
    assign out_err = m_q.err;

    // Convert the incoming transaction; lowest set bit wins on decode.
    always_comb begin
        res = '0;
        res.mode = in_mode;
        if (!in_mode) begin
            res.bin = in_bin;
            res.onehot = ONEHOT_WIDTH'(1) << in_bin;
        end else begin
            res.onehot = in_onehot;
            for (int i = ONEHOT_WIDTH - 1; i >= 0; i--) begin
                if (in_onehot[i]) begin
                    res.bin = BIN_WIDTH'(i);
                end
            end
`ifdef ONEHOT_CODEC_ERR_EN
            res.err = (in_onehot == '0) ||
                      ((in_onehot & (in_onehot - ONEHOT_WIDTH'(1))) != '0);
`endif
        end
    end

    // Main/skid storage: S refills M on drain, new data lands in M or S.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_full <= 1'b0;
            s_full <= 1'b0;
            m_q    <= '0;
            s_q    <= '0;
        end else if (out_fire) begin
            if (s_full) begin
                m_q    <= s_q;
                s_full <= 1'b0;
            end else if (in_fire) begin
                m_q    <= res;
            end else begin
                m_full <= 1'b0;
            end
        end else if (in_fire) begin
            if (!m_full) begin
                m_q    <= res;
                m_full <= 1'b1;
            end else begin
                s_q    <= res;
                s_full <= 1'b1;
            end
        end
    end

`ifdef ONEHOT_CODEC_ERR_EN
    logic [7:0] err_cnt_q;

    // Count accepted erroneous decodes, saturating at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (in_fire && res.err && err_cnt_q != 8'hff) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_onehot_codec.sv
// tb_onehot_codec: directed self-checking bench for onehot_codec.
// Expected error values follow ONEHOT_CODEC_ERR_EN.
module tb_onehot_codec;

`ifdef ONEHOT_CODEC_ERR_EN
    localparam bit E = 1'b1;
`else
    localparam bit E = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [3:0]  in_bin;
    logic [15:0] in_onehot;
    logic        out_valid;
    logic        out_ready;
    logic        out_mode;
    logic [15:0] out_onehot;
    logic [3:0]  out_bin;
    logic        out_err;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_fail = 0;

    onehot_codec #(.BIN_WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_bin     (in_bin),
        .in_onehot  (in_onehot),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mode   (out_mode),
        .out_onehot (out_onehot),
        .out_bin    (out_bin),
        .out_err    (out_err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic mode, input logic [3:0] b,
                        input logic [15:0] oh);
        in_valid = 1'b1;
        in_mode = mode;
        in_bin = b;
        in_onehot = oh;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int sent;
        int got;
        logic iv;
        logic ov;
        logic [15:0] ob;
        logic [15:0] e;

        rst = 1'b1;
        in_valid = 1'b0;
        in_mode = 1'b0;
        in_bin = '0;
        in_onehot = '0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_mode", out_mode, 0);
        chk("rst_out_bin", out_bin, 0);
        chk("rst_out_onehot", out_onehot, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_err_count", err_count, 0);
        rst = 1'b0;
        step();

        send(1'b0, 4'd5, 16'h0);
        chk("enc5_valid", out_valid, 1);
        chk("enc5_onehot", out_onehot, 16'h0020);
        chk("enc5_err", out_err, 0);
        chk("enc5_in_ready", in_ready, 1);
        chk("enc5_mode", out_mode, 0);
        chk("enc5_bin_echo", out_bin, 5);

        send(1'b0, 4'd0, 16'h0);
        chk("enc0_onehot", out_onehot, 16'h0001);
        send(1'b0, 4'd15, 16'h0);
        chk("enc15_onehot", out_onehot, 16'h8000);

        send(1'b1, 4'd0, 16'h0400);
        chk("dec400_bin", out_bin, 10);
        chk("dec400_err", out_err, 0);
        chk("dec400_mode", out_mode, 1);
        chk("dec400_echo", out_onehot, 16'h0400);

        send(1'b1, 4'd0, 16'h0000);
        chk("dec0_bin", out_bin, 0);
        chk("dec0_err", out_err, E);
        chk("dec0_cnt", err_count, E ? 1 : 0);

        send(1'b1, 4'd0, 16'h0006);
        chk("dec6_bin", out_bin, 1);
        chk("dec6_err", out_err, E);
        chk("dec6_cnt", err_count, E ? 2 : 0);

        send(1'b1, 4'd0, 16'h8000);
        chk("dec8000_bin", out_bin, 15);
        chk("dec8000_err", out_err, 0);

        send(1'b1, 4'd0, 16'hffff);
        chk("decffff_bin", out_bin, 0);
        chk("decffff_err", out_err, E);
        chk("decffff_cnt", err_count, E ? 3 : 0);

        step();
        chk("drained", out_valid, 0);

        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
            in_valid = (sent < 16);
            in_mode = 1'b0;
            in_bin = 4'(sent);
            out_ready = !(cyc >= 2 && cyc < 6);
            if (cyc == 3) begin
                chk("bp_in_ready", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
                chk("bp_held", out_onehot, 16'h0002);
            end
            if (cyc == 5) begin
                chk("bp_stable", out_onehot, 16'h0002);
            end
            iv = in_valid && in_ready;
            ov = out_valid && out_ready;
            ob = out_onehot;
            step();
            if (iv) sent++;
            if (ov) begin
                e = 16'h1 << got;
                chk("stream", ob, e);
                got++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", got, 16);
        step();
        step();
        chk("stream_no_dup", out_valid, 0);

        in_valid = 1'b1;
        in_mode = 1'b1;
        in_onehot = 16'h0000;
        repeat (251) @(posedge clk);
        #1;
        chk("sat_254", err_count, E ? 254 : 0);
        repeat (49) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("sat_255", err_count, E ? 255 : 0);
        step();

        out_ready = 1'b0;
        send(1'b0, 4'd3, 16'h0);
        send(1'b1, 4'd0, 16'h0000);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        rst = 1'b1;
        step();
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_err_count", err_count, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("mrst_no_stale", out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
